// File: rtl/core_lsu_queue_pkg.sv
// Shared types for the load/store queue: memory handshake structs and the ring-buffer entry.
package core_lsu_queue_pkg;

    localparam int LSU_DATA_W = 32;
    localparam int LSU_RD_W   = 6;

    typedef struct packed {
        logic [LSU_DATA_W-1:0] write_data;
        logic                  valid;
        logic                  wen;
        logic                  byte_not_word;
        logic                  yumi;
    } mem_in_s;

    typedef struct packed {
        logic [LSU_DATA_W-1:0] read_data;
        logic                  valid;
        logic                  yumi;
    } mem_out_s;

    typedef struct packed {
        logic                  wen;
        logic                  byte_op;
        logic [LSU_DATA_W-1:0] addr;
        logic [LSU_DATA_W-1:0] wdata;
        logic [LSU_RD_W-1:0]   rd;
    } lsu_entry_s;

    function automatic logic [LSU_DATA_W-1:0] replicate_byte(input logic [7:0] b);
        return {(LSU_DATA_W/8){b}};
    endfunction

endpackage

// File: rtl/core_lsu_queue.sv
// In-order load/store queue: ring buffer with separate write, issue and retire pointers.
// Struct field widths come from the package, so DATA_W_P/RD_W_P must match its constants.
module core_lsu_queue
    import core_lsu_queue_pkg::*;
#(
    parameter int DEPTH_P   = 4,
    parameter int MAX_OUT_P = 2,
    parameter int DATA_W_P  = LSU_DATA_W,
    parameter int RD_W_P    = LSU_RD_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_wen_i,
    input  logic                      req_byte_i,
    input  logic [DATA_W_P-1:0]       req_addr_i,
    input  logic [DATA_W_P-1:0]       req_wdata_i,
    input  logic [RD_W_P-1:0]         req_rd_i,
    input  logic                      flush_i,
    output mem_in_s                   to_mem_o,
    output logic [DATA_W_P-1:0]       mem_addr_o,
    input  mem_out_s                  from_mem_i,
    output logic                      wb_valid_o,
    input  logic                      wb_ready_i,
    output logic [RD_W_P-1:0]         wb_rd_o,
    output logic [DATA_W_P-1:0]       wb_data_o,
    output logic                      busy_o,
    output logic [$clog2(DEPTH_P):0]  count_o
);

    localparam int IDX_W = $clog2(DEPTH_P);
    localparam int PTR_W = IDX_W + 1;

    lsu_entry_s         buf_q [DEPTH_P];
    logic [PTR_W-1:0]   wr_q, wr_d;
    logic [PTR_W-1:0]   iss_q, iss_d;
    logic [PTR_W-1:0]   ret_q, ret_d;

    logic [PTR_W-1:0]   count_s;
    logic [PTR_W-1:0]   inflight_s;
    logic [IDX_W-1:0]   iss_idx_s;
    logic [IDX_W-1:0]   ret_idx_s;
    logic               accept_s;
    logic               issue_valid_s;
    logic               issue_fire_s;
    logic               resp_live_s;
    logic               retire_s;
    logic [DATA_W_P-1:0] load_data_s;

    // Pointer differences carry the wrap bit, so full and empty stay distinct.
    assign count_s       = wr_q - ret_q;
    assign inflight_s    = iss_q - ret_q;
    assign iss_idx_s     = iss_q[IDX_W-1:0];
    assign ret_idx_s     = ret_q[IDX_W-1:0];

    assign req_ready_o   = (count_s < PTR_W'(DEPTH_P));
    assign accept_s      = req_valid_i & req_ready_o & ~flush_i;
    assign issue_valid_s = (iss_q != wr_q) & (inflight_s < PTR_W'(MAX_OUT_P));
    assign issue_fire_s  = issue_valid_s & from_mem_i.yumi;

    // A response with nothing in flight is stale (e.g. from before a reset) and is ignored.
    assign resp_live_s   = from_mem_i.valid & (ret_q != iss_q);
    assign wb_valid_o    = resp_live_s & ~buf_q[ret_idx_s].wen;
    assign retire_s      = resp_live_s & (buf_q[ret_idx_s].wen | wb_ready_i);

    assign busy_o        = (count_s != {PTR_W{1'b0}});
    assign count_o       = count_s;

    // Next-state pointers; a flush rewinds wr to the post-issue iss and drops any accept.
    always_comb begin
        iss_d = iss_q;
        ret_d = ret_q;
        wr_d  = wr_q;
        if (issue_fire_s) begin
            iss_d = iss_q + PTR_W'(1);
        end else begin
            iss_d = iss_q;
        end
        if (retire_s) begin
            ret_d = ret_q + PTR_W'(1);
        end else begin
            ret_d = ret_q;
        end
        if (flush_i) begin
            wr_d = iss_d;
        end else if (accept_s) begin
            wr_d = wr_q + PTR_W'(1);
        end else begin
            wr_d = wr_q;
        end
    end

    // Pointer and entry storage registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_q  <= '0;
            iss_q <= '0;
            ret_q <= '0;
            for (int i = 0; i < DEPTH_P; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            iss_q <= iss_d;
            ret_q <= ret_d;
            if (accept_s) begin
                buf_q[wr_q[IDX_W-1:0]] <= '{wen:     req_wen_i,
                                            byte_op: req_byte_i,
                                            addr:    req_addr_i,
                                            wdata:   req_wdata_i,
                                            rd:      req_rd_i};
            end else begin
                buf_q[wr_q[IDX_W-1:0]] <= buf_q[wr_q[IDX_W-1:0]];
            end
        end
    end

    // Memory request from the oldest waiting entry; fields read zero while idle.
    always_comb begin
        to_mem_o      = '0;
        mem_addr_o    = '0;
        to_mem_o.yumi = retire_s;
        if (issue_valid_s) begin
            to_mem_o.valid         = 1'b1;
            to_mem_o.wen           = buf_q[iss_idx_s].wen;
            to_mem_o.byte_not_word = buf_q[iss_idx_s].byte_op;
            to_mem_o.write_data    = buf_q[iss_idx_s].byte_op
                                   ? replicate_byte(buf_q[iss_idx_s].wdata[7:0])
                                   : buf_q[iss_idx_s].wdata;
            mem_addr_o             = buf_q[iss_idx_s].addr;
        end else begin
            to_mem_o.valid         = 1'b0;
        end
    end

    // Byte-lane select with zero extension for LBU; words pass through.
    always_comb begin
        load_data_s = '0;
        if (buf_q[ret_idx_s].byte_op) begin
            case (buf_q[ret_idx_s].addr[1:0])
                2'd0:    load_data_s = {{(DATA_W_P-8){1'b0}}, from_mem_i.read_data[7:0]};
                2'd1:    load_data_s = {{(DATA_W_P-8){1'b0}}, from_mem_i.read_data[15:8]};
                2'd2:    load_data_s = {{(DATA_W_P-8){1'b0}}, from_mem_i.read_data[23:16]};
                2'd3:    load_data_s = {{(DATA_W_P-8){1'b0}}, from_mem_i.read_data[31:24]};
                default: load_data_s = '0;
            endcase
        end else begin
            load_data_s = from_mem_i.read_data;
        end
    end

    // Writeback fields are only meaningful alongside wb_valid_o.
    always_comb begin
        wb_rd_o   = '0;
        wb_data_o = '0;
        if (wb_valid_o) begin
            wb_rd_o   = buf_q[ret_idx_s].rd;
            wb_data_o = load_data_s;
        end else begin
            wb_rd_o   = '0;
            wb_data_o = '0;
        end
    end

endmodule
